uart_reg_bridge: RTL and testbench

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

---
 rtl/uart_reg_bridge.sv | 194 +++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
// Byte-stream register bridge: decodes read/write frames from a receive FIFO,
// executes them against a small register file, and pushes a one-byte response.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | wait for a command byte; unknown commands go straight to SEND
// GET_ADDR | pop the address byte (idle-byte timeout armed)
// GET_DATA | pop the write data byte (idle-byte timeout armed)
// EXEC     | one cycle: apply write / select read value, bump a counter
// SEND     | push the response byte once the transmit FIFO has room
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT  = 50000,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter logic [7:0]  NAK_BYTE = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_full,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic [47:0] regs_out
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  // Down-counter preloaded with TIMEOUT-1 on every pop; terminal count at zero.
  localparam int unsigned    TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    SEND
  } state_t;

  state_t        state, state_nxt;
  logic          armed;
  logic [7:0]    cmd_q, addr_q, wdata_q;
  logic [7:0]    resp_q, tx_hold_q;
  logic [47:0]   regs_q;
  logic [7:0]    frame_cnt, err_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          cmd_valid;
  logic          exec_ok;
  logic [7:0]    exec_resp;

  assign cmd_valid = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign regs_out  = regs_q;
  // Only a push moves tx_data; between pushes it shows the last byte sent.
  assign tx_data   = tx_wr ? resp_q : tx_hold_q;

  // State register; armed delays the first pop to the second edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Next-state decode and the pop/push strobes.
  always_comb begin
    state_nxt = state;
    rx_rd     = 1'b0;
    tx_wr     = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_empty) begin
          rx_rd     = 1'b1;
          state_nxt = cmd_valid ? GET_ADDR : SEND;
        end
      end
      GET_ADDR: begin
        if (!rx_empty) begin
          rx_rd     = 1'b1;
          state_nxt = (cmd_q == CMD_WR) ? GET_DATA : EXEC;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GET_DATA: begin
        if (!rx_empty) begin
          rx_rd     = 1'b1;
          state_nxt = EXEC;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        state_nxt = SEND;
      end
      SEND: begin
        if (!tx_full) begin
          tx_wr     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame decode: legality and the response byte for the frame held in cmd/addr.
  always_comb begin
    exec_ok   = 1'b0;
    exec_resp = NAK_BYTE;
    if (cmd_q == CMD_WR) begin
      if (addr_q <= 8'd5) begin
        exec_ok   = 1'b1;
        exec_resp = ACK_BYTE;
      end
    end else if (addr_q <= 8'd7) begin
      exec_ok = 1'b1;
      if (addr_q[2:0] == 3'd6) begin
        exec_resp = frame_cnt;
      end else if (addr_q[2:0] == 3'd7) begin
        exec_resp = err_cnt;
      end else begin
        for (int i = 0; i < 6; i++) begin
          if (addr_q[2:0] == 3'(i)) exec_resp = regs_q[8*i +: 8];
        end
      end
    end
  end

  // Datapath: byte capture, timeout timer, register file, counters, response.
  // Counter reads in EXEC see the pre-increment value since both share the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_q    <= '0;
      tx_hold_q <= '0;
      regs_q    <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (rx_rd) begin
        tmo_cnt <= TMO_LOAD;
        case (state)
          IDLE:     cmd_q   <= rx_data;
          GET_ADDR: addr_q  <= rx_data;
          GET_DATA: wdata_q <= rx_data;
          default:  ;
        endcase
      end else if (((state == GET_ADDR) || (state == GET_DATA)) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end

      if ((state == IDLE) && rx_rd && !cmd_valid) begin
        resp_q  <= NAK_BYTE;
        err_cnt <= err_cnt + 8'd1;
      end

      if (tmo_hit) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (state == EXEC) begin
        resp_q <= exec_resp;
        if (exec_ok) begin
          frame_cnt <= frame_cnt + 8'd1;
          if (cmd_q == CMD_WR) begin
            for (int i = 0; i < 6; i++) begin
              if (addr_q[2:0] == 3'(i)) regs_q[8*i +: 8] <= wdata_q;
            end
          end
        end else begin
          err_cnt <= err_cnt + 8'd1;
        end
      end

      if (tx_wr) begin
        tx_hold_q <= resp_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: FWFT receive FIFO model, response scoreboard fed
// by a frame-level reference model, directed scenarios plus random traffic.
module tb_uart_reg_bridge;

  localparam int         TMO = 10;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h3F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        tx_full = 1'b0;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic [47:0] regs_out;

  uart_reg_bridge #(.TIMEOUT(TMO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .rx_data  (rx_data),
    .rx_rd    (rx_rd),
    .tx_full  (tx_full),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .regs_out (regs_out)
  );

  always #5 clk = ~clk;

  // Receive FIFO: first-word-fall-through, popped on the rising edge.
  logic [7:0] fifo_mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_data  = fifo_mem[rd_ptr];
  always @(posedge clk) if (rx_rd) rd_ptr <= rd_ptr + 8'd1;

  // Transmit FIFO full flag: random or forced, changed just after the edge.
  logic rand_full  = 1'b0;
  logic force_full = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_full = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: register contents, counters, expected response stream.
  logic [7:0] m_regs [0:5];
  logic [7:0] m_fc, m_ec;
  logic [7:0] expq [$];

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_regs[i] = 8'd0;
    m_fc = 8'd0;
    m_ec = 8'd0;
  endtask

  task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    if (c == 8'h57 && a <= 8'd5) begin
      m_regs[a[2:0]] = d;
      expq.push_back(ACK);
      m_fc = m_fc + 8'd1;
    end else if (c == 8'h52 && a <= 8'd7) begin
      if (a == 8'd6)      expq.push_back(m_fc);
      else if (a == 8'd7) expq.push_back(m_ec);
      else                expq.push_back(m_regs[a[2:0]]);
      m_fc = m_fc + 8'd1;
    end else begin
      expq.push_back(NAK);
      m_ec = m_ec + 8'd1;
    end
  endtask

  function automatic logic [47:0] m_pack();
    logic [47:0] p;
    for (int i = 0; i < 6; i++) p[8*i +: 8] = m_regs[i];
    return p;
  endfunction

  // Monitor, sampled on the falling edge where all signals are settled.
  int cyc = 0;
  int last_pop_cyc = 0;
  int last_lat = 0;
  int tx_count = 0;
  int extra_tx = 0;
  int pop_viol = 0;
  int full_viol = 0;
  int tx_cycs [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_rd) begin
      if (rx_empty) pop_viol++;
      last_pop_cyc = cyc;
    end
    if (tx_wr) begin
      if (tx_full) full_viol++;
      tx_count++;
      last_lat = cyc - last_pop_cyc;
      tx_cycs.push_back(cyc);
      if (expq.size() == 0) extra_tx++;
      else chk("tx_byte", 32'(tx_data), 32'(expq.pop_front()));
    end
  end

  task automatic push_now(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    push_now(b);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input int max_gap);
    model_frame(c, a, d);
    push_byte(c);
    if (c == 8'h57 || c == 8'h52) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      push_byte(a);
      if (c == 8'h57) begin
        repeat ($urandom_range(0, max_gap)) @(posedge clk);
        push_byte(d);
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int k = 0;
    while ((expq.size() != 0 || wr_ptr != rd_ptr) && k < bound) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  // Returns just after the edge on which the FIFO became empty.
  task automatic sync_popped(input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (rd_ptr != wr_ptr && k < 50);
    chk(tag, 32'(rd_ptr), 32'(wr_ptr));
  endtask

  int tc;
  int n0;
  logic [7:0] rc, ra, rdv;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #11;
    push_now(8'h13);
    model_frame(8'h13, 8'h00, 8'h00);
    #1;
    chk("rst_rx_rd",    32'(rx_rd),   32'd0);
    chk("rst_tx_wr",    32'(tx_wr),   32'd0);
    chk("rst_tx_data",  32'(tx_data), 32'd0);
    chk("rst_regs_lo",  regs_out[31:0], 32'd0);
    chk("rst_regs_hi",  32'(regs_out[47:32]), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("rx_rd_before_edge1", 32'(rx_rd), 32'd0);
    @(posedge clk);
    #1 chk("no_pop_edge1", 32'(rd_ptr), 32'd0);
    wait_drain("drain_reset_byte", 100);

    // write then read back, plus frame counter
    send_frame(8'h57, 8'h02, 8'hA5, 0);
    wait_drain("drain_wr", 100);
    chk("wr_latency", 32'(last_lat), 32'd2);
    chk("reg2_after_wr", 32'(regs_out[23:16]), 32'(m_regs[2]));
    send_frame(8'h52, 8'h02, 8'h00, 0);
    send_frame(8'h52, 8'h06, 8'h00, 0);
    wait_drain("drain_rd", 100);

    // rejected frames, then error counter
    send_frame(8'h13, 8'h00, 8'h00, 0);
    send_frame(8'h57, 8'h06, 8'h11, 0);
    send_frame(8'h52, 8'h09, 8'h00, 0);
    send_frame(8'h52, 8'h07, 8'h00, 0);
    wait_drain("drain_bad", 100);
    chk("regs_after_bad_lo", regs_out[31:0], m_pack()[31:0]);

    // backpressure on the response
    @(negedge clk) force_full = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h52, 8'h00, 8'h00, 0);
    sync_popped("bp_popped");
    tc = tx_count;
    repeat (22) @(negedge clk);
    chk("bp_no_tx", 32'(tx_count), 32'(tc));
    force_full = 1'b0;
    @(negedge clk);
    chk("bp_tx_wr",   32'(tx_wr),   32'd1);
    chk("bp_tx_data", 32'(tx_data), 32'(m_regs[0]));
    @(negedge clk);
    chk("bp_single",  32'(tx_wr),   32'd0);
    wait_drain("drain_bp", 100);

    // timeout exactly at the limit: frame dropped, next bytes form a new frame
    @(posedge clk);
    #1;
    push_now(8'h57);
    push_now(8'h01);
    m_ec = m_ec + 8'd1;
    sync_popped("tmo_popped");
    repeat (10) @(posedge clk);
    #1;
    model_frame(8'h52, 8'h07, 8'h00);
    push_now(8'h52);
    push_now(8'h07);
    wait_drain("drain_tmo", 200);

    // byte arriving in the last allowed idle cycle: frame continues
    @(posedge clk);
    #1;
    push_now(8'h57);
    push_now(8'h01);
    model_frame(8'h57, 8'h01, 8'hC3);
    sync_popped("tmo_edge_popped");
    repeat (9) @(posedge clk);
    #1;
    push_now(8'hC3);
    wait_drain("drain_tmo_edge", 200);
    chk("reg1_tmo_edge", 32'(regs_out[15:8]), 32'(m_regs[1]));

    // timeout while waiting for the address
    push_byte(8'h52);
    m_ec = m_ec + 8'd1;
    repeat (20) @(posedge clk);
    send_frame(8'h52, 8'h07, 8'h00, 0);
    wait_drain("drain_tmo_addr", 200);

    // reset in the middle of a write frame
    @(posedge clk);
    #1;
    push_now(8'h57);
    push_now(8'h03);
    sync_popped("mid_popped");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mid_rst_regs_lo", regs_out[31:0], 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    send_frame(8'h52, 8'h03, 8'h00, 0);
    send_frame(8'h52, 8'h06, 8'h00, 0);
    wait_drain("drain_mid_rst", 100);

    // three write frames preloaded back to back
    n0 = tx_cycs.size();
    @(posedge clk);
    #1;
    for (int f = 0; f < 3; f++) begin
      ra  = 8'($urandom_range(0, 5));
      rdv = 8'($urandom_range(0, 255));
      model_frame(8'h57, ra, rdv);
      push_now(8'h57);
      push_now(ra);
      push_now(rdv);
    end
    wait_drain("drain_b2b", 200);
    chk("b2b_gap1", 32'(tx_cycs[n0+1] - tx_cycs[n0]),   32'd5);
    chk("b2b_gap2", 32'(tx_cycs[n0+2] - tx_cycs[n0+1]), 32'd5);

    // random traffic with random backpressure
    rand_full = 1'b1;
    for (int f = 0; f < 60; f++) begin
      n0 = $urandom_range(0, 9);
      if (n0 < 5)      rc = 8'h57;
      else if (n0 < 9) rc = 8'h52;
      else begin
        rc = 8'($urandom_range(0, 255));
        if (rc == 8'h57 || rc == 8'h52) rc = 8'h00;
      end
      ra  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8));
      rdv = 8'($urandom_range(0, 255));
      send_frame(rc, ra, rdv, 3);
    end
    wait_drain("drain_rand", 5000);
    rand_full = 1'b0;
    send_frame(8'h52, 8'h06, 8'h00, 0);
    send_frame(8'h52, 8'h07, 8'h00, 0);
    wait_drain("drain_final", 200);
    chk("final_regs_lo", regs_out[31:0], m_pack()[31:0]);
    chk("final_regs_hi", 32'(regs_out[47:32]), 32'(m_pack()[47:32]));
    chk("pop_when_empty", 32'(pop_viol), 32'd0);
    chk("push_when_full", 32'(full_viol), 32'd0);
    chk("unexpected_tx",  32'(extra_tx), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
